addsub_seq: RTL and testbench

- Multi-cycle sequencer that computes a WIDTH-bit add or subtract by time-sharing one SLICE-bit ripple add/sub slice, least-significant slice first.
- The carry is held in a flop between passes.
- Sits in the NeanderRV64 execute stage as the area-lean adder path for 64-bit ALU ops.
- Result convention: S = B + A when D=0; S = B - A when D=1.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_slice.sv | 32 +++
 rtl/addsub_seq.sv | 173 +++++++++++++++++
 tb/tb_addsub_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and constants for the sliced add/sub sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  // Operation select encoding on the d input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module      : addsub_slice
// Description : SLICE-bit combinational ripple adder with explicit carry-in.
//               The caller pre-inverts the subtrahend and feeds cin=1 on the
//               first pass, so the slice itself never needs to know the op.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_s,
  output logic             o_cout
);

  // Ripple carry chain; w_c[k] is the carry into bit k
  logic [SLICE:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < SLICE; k++) begin : g_bit
    assign o_s[k]     = i_a[k] ^ i_b[k] ^ w_c[k];
    assign w_c[k + 1] = (i_a[k] & i_b[k]) | (w_c[k] & (i_a[k] ^ i_b[k]));
  end

  assign o_cout = w_c[SLICE];

endmodule : addsub_slice
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : addsub_seq
// Description : Multi-cycle WIDTH-bit add/subtract built by time-sharing one
//               SLICE-bit ripple slice, least-significant slice first.
//               S = B + A (d=0) or S = B - A (d=1).
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_d,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NSLICE - 1);

  // Width must split into whole slices
  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("addsub_seq: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_eff;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sum_sl;
  logic             w_cout_sl;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_ovf_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs; start is only honoured when ready
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (r_idx == c_LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_ready = 1'b1;
        o_done  = 1'b1;
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Select the operand slices for the current pass
  always_comb begin
    w_a_sl = r_a_eff[r_idx * SLICE +: SLICE];
    w_b_sl = r_b[r_idx * SLICE +: SLICE];
  end

  addsub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_s    (w_sum_sl),
    .o_cout (w_cout_sl)
  );

  // Accumulator with the current pass merged in; on the last pass this is the full result
  always_comb begin
    w_acc_nxt                        = r_acc;
    w_acc_nxt[r_idx * SLICE +: SLICE] = w_sum_sl;
    w_ovf_nxt = (r_a_eff[WIDTH-1] == r_b[WIDTH-1]) &&
                (w_acc_nxt[WIDTH-1] != r_b[WIDTH-1]);
  end

  // Operand latches, pass accumulation and result capture.
  // Partial sums live only in r_acc; r_s/flags update once, on entry to DONE,
  // so the visible result never shows a half-finished operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_eff <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a_eff <= (i_d == OP_SUB) ? ~i_a : i_a;
      r_b     <= i_b;
      r_carry <= i_d;
      r_idx   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_RUN) begin
      r_acc   <= w_acc_nxt;
      r_carry <= w_cout_sl;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_s    <= w_acc_nxt;
        r_cout <= w_cout_sl;
        r_ovf  <= w_ovf_nxt;
        r_zero <= (w_acc_nxt == '0);
      end
    end
  end

  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;
  assign o_zero = r_zero;

endmodule : addsub_seq
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_seq
// Description : Directed self-checking bench for addsub_seq; one 8/4 instance
//               for the corner cases and one default 64/16 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit / 4-bit slice instance
  logic       i8_start, i8_d;
  logic [7:0] i8_a, i8_b;
  logic       o8_ready, o8_busy, o8_done, o8_cout, o8_ovf, o8_zero;
  logic [7:0] o8_s;

  // 64-bit / 16-bit slice instance
  logic        i64_start, i64_d;
  logic [63:0] i64_a, i64_b;
  logic        o64_ready, o64_busy, o64_done, o64_cout, o64_ovf, o64_zero;
  logic [63:0] o64_s;

  int n_checks = 0;
  int n_errors = 0;

  addsub_seq #(.WIDTH(8), .SLICE(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(i8_start), .i_d(i8_d), .i_a(i8_a), .i_b(i8_b),
    .o_ready(o8_ready), .o_busy(o8_busy), .o_done(o8_done), .o_s(o8_s),
    .o_cout(o8_cout), .o_ovf(o8_ovf), .o_zero(o8_zero)
  );

  addsub_seq u_dut64 (
    .clk(clk), .rst_n(rst_n), .i_start(i64_start), .i_d(i64_d), .i_a(i64_a), .i_b(i64_b),
    .o_ready(o64_ready), .o_busy(o64_busy), .o_done(o64_done), .o_s(o64_s),
    .o_cout(o64_cout), .o_ovf(o64_ovf), .o_zero(o64_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one 8-bit op; imm=1 drives start in the current (DONE) cycle.
  // lat = number of rising edges from the start edge up to the observed done.
  task automatic op8(input logic imm, input logic d, input logic [7:0] a,
                     input logic [7:0] b, output int lat);
    if (!imm) @(negedge clk);
    i8_start = 1'b1; i8_d = d; i8_a = a; i8_b = b;
    @(negedge clk);
    i8_start = 1'b0;
    lat = 1;
    while (!o8_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op64(input logic d, input logic [63:0] a, input logic [63:0] b,
                      output int lat);
    @(negedge clk);
    i64_start = 1'b1; i64_d = d; i64_a = a; i64_b = b;
    @(negedge clk);
    i64_start = 1'b0;
    lat = 1;
    while (!o64_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [64:0] ref_sum;
    logic [63:0] ra, rb, rs;
    logic        rd, rovf;

    rst_n = 1'b0;
    i8_start = 1'b0;  i8_d = 1'b0;  i8_a = '0;  i8_b = '0;
    i64_start = 1'b0; i64_d = 1'b0; i64_a = '0; i64_b = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", o8_ready, 1);
    check("rst_busy",  o8_busy,  0);
    check("rst_done",  o8_done,  0);
    check("rst_s",     o8_s,     0);
    check("rst_flags", {o8_cout, o8_ovf, o8_zero}, 0);
    check("rst_ready64", o64_ready, 1);
    rst_n = 1'b1;

    // Add with inter-slice carry
    op8(1'b0, 1'b0, 8'h0F, 8'h01, lat);
    check("add_lat",  lat, 3);
    check("add_s",    o8_s, 8'h10);
    check("add_cout", o8_cout, 0);
    check("add_ovf",  o8_ovf, 0);
    check("add_zero", o8_zero, 0);
    check("add_ready", o8_ready, 1);

    // Subtract with wrap, then back-to-back from the DONE cycle
    op8(1'b0, 1'b1, 8'h01, 8'h00, lat);
    check("sub_s",    o8_s, 8'hFF);
    check("sub_cout", o8_cout, 0);
    check("sub_ovf",  o8_ovf, 0);
    op8(1'b1, 1'b1, 8'h01, 8'h01, lat);
    check("b2b_lat",  lat, 3);
    check("b2b_s",    o8_s, 8'h00);
    check("b2b_zero", o8_zero, 1);
    check("b2b_cout", o8_cout, 1);

    // Signed overflow, both directions
    op8(1'b0, 1'b0, 8'h7F, 8'h01, lat);
    check("ovfa_s",    o8_s, 8'h80);
    check("ovfa_ovf",  o8_ovf, 1);
    check("ovfa_cout", o8_cout, 0);
    op8(1'b0, 1'b1, 8'h01, 8'h80, lat);
    check("ovfs_s",    o8_s, 8'h7F);
    check("ovfs_ovf",  o8_ovf, 1);
    check("ovfs_cout", o8_cout, 1);

    // Start and operand changes during RUN are ignored
    @(negedge clk);
    i8_start = 1'b1; i8_d = 1'b0; i8_a = 8'h12; i8_b = 8'h34;
    @(negedge clk);
    i8_d = 1'b1; i8_a = 8'hAA; i8_b = 8'h55;
    check("ign_busy1", o8_busy, 1);
    @(negedge clk);
    check("ign_busy2", o8_busy, 1);
    @(negedge clk);
    i8_start = 1'b0;
    check("ign_done", o8_done, 1);
    check("ign_s",    o8_s, 8'h46);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (o8_done) ndone++;
    end
    check("ign_extra_done", ndone, 0);

    // Asynchronous reset after one RUN cycle: no done, outputs cleared
    @(negedge clk);
    i8_start = 1'b1; i8_d = 1'b0; i8_a = 8'h0F; i8_b = 8'h01;
    @(negedge clk);
    i8_start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_ready", o8_ready, 1);
    check("mid_busy",  o8_busy, 0);
    check("mid_s",     o8_s, 8'h00);
    check("mid_flags", {o8_cout, o8_ovf, o8_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (o8_done) ndone++;
    end
    check("mid_no_done", ndone, 0);

    // Default 64/16: 0 - all-ones wraps to 1
    op64(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, lat);
    check("w64_lat",  lat, 5);
    check("w64_s",    o64_s, 64'h1);
    check("w64_cout", o64_cout, 0);
    check("w64_ovf",  o64_ovf, 0);

    // Random add/sub against an arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      ra = {$urandom, $urandom};
      rb = (n % 50 == 0) ? ra : {$urandom, $urandom};
      rd = $urandom_range(0, 1) == 1;
      if (rd) ref_sum = {1'b0, rb} + {1'b0, ~ra} + 65'd1;
      else    ref_sum = {1'b0, rb} + {1'b0, ra};
      rs = ref_sum[63:0];
      if (rd) rovf = (ra[63] != rb[63]) && (rs[63] != rb[63]);
      else    rovf = (ra[63] == rb[63]) && (rs[63] != rb[63]);
      op64(rd, ra, rb, lat);
      check("rnd_lat",  lat, 5);
      check("rnd_s",    o64_s, rs);
      check("rnd_cout", o64_cout, ref_sum[64]);
      check("rnd_ovf",  o64_ovf, rovf);
      check("rnd_zero", o64_zero, rs == 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_addsub_seq
`default_nettype wire
